// File: rtl/div_bcd_formatter_if.sv
// rtl/div_bcd_formatter_if.sv - divider result / BCD output bundle for div_bcd_formatter
interface div_bcd_formatter_if;
    logic        div_done;
    logic [7:0]  div_q;
    logic [7:0]  div_rem;
    logic [7:0]  div_b;
    logic        out_ready;
    logic        out_valid;
    logic [11:0] q_bcd;
    logic [11:0] r_bcd;
    logic        dz_err;
    logic        busy;
    logic        overrun;

    // Divider plus downstream consumer side
    modport master (
        output div_done, div_q, div_rem, div_b, out_ready,
        input  out_valid, q_bcd, r_bcd, dz_err, busy, overrun
    );

    // Formatter side
    modport slave (
        input  div_done, div_q, div_rem, div_b, out_ready,
        output out_valid, q_bcd, r_bcd, dz_err, busy, overrun
    );
endinterface

// File: rtl/div_bcd_formatter.sv
// rtl/div_bcd_formatter.sv - latches divider results and converts them to 3-digit BCD
module div_bcd_formatter (
    input logic             clk,
    input logic             reset,
    div_bcd_formatter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

    state_t      state_q, state_d;
    logic        done_q, done_d;
    logic [7:0]  sq_q, sq_d, sr_q, sr_d;
    logic [11:0] qacc_q, qacc_d, racc_q, racc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        dz_next_q, dz_next_d;
    logic [11:0] q_bcd_q, q_bcd_d, r_bcd_q, r_bcd_d;
    logic        dz_err_q, dz_err_d;
    logic        out_valid_q, out_valid_d;
    logic        overrun_q, overrun_d;

    logic        start;
    logic [19:0] q_step, r_step;

    // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd, s} left by one.
    function automatic logic [19:0] dd_step(input logic [11:0] bcd, input logic [7:0] s);
        logic [11:0] adj;
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        return {adj[10:0], s, 1'b0};
    endfunction

    assign start  = bus.div_done & ~done_q;
    assign q_step = dd_step(qacc_q, sq_q);
    assign r_step = dd_step(racc_q, sr_q);

    // Next-state and datapath decisions for the capture / convert / hold sequence
    always_comb begin
        state_d     = state_q;
        done_d      = bus.div_done;
        sq_d        = sq_q;
        sr_d        = sr_q;
        qacc_d      = qacc_q;
        racc_d      = racc_q;
        cnt_d       = cnt_q;
        dz_next_d   = dz_next_q;
        q_bcd_d     = q_bcd_q;
        r_bcd_d     = r_bcd_q;
        dz_err_d    = dz_err_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sq_d      = bus.div_q;
                    sr_d      = bus.div_rem;
                    dz_next_d = (bus.div_b == 8'd0);
                    qacc_d    = 12'd0;
                    racc_d    = 12'd0;
                    cnt_d     = 3'd0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                {qacc_d, sq_d} = q_step;
                {racc_d, sr_d} = r_step;
                cnt_d          = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    q_bcd_d     = q_step[19:8];
                    r_bcd_d     = r_step[19:8];
                    dz_err_d    = dz_next_q;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
                // A completion arriving mid-conversion is dropped, not queued
                if (start) begin
                    overrun_d = 1'b1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (start) begin
                        sq_d      = bus.div_q;
                        sr_d      = bus.div_rem;
                        dz_next_d = (bus.div_b == 8'd0);
                        qacc_d    = 12'd0;
                        racc_d    = 12'd0;
                        cnt_d     = 3'd0;
                        state_d   = CONV;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (start) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; done_q resets high so a held div_done is not an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            done_q      <= 1'b1;
            sq_q        <= 8'd0;
            sr_q        <= 8'd0;
            qacc_q      <= 12'd0;
            racc_q      <= 12'd0;
            cnt_q       <= 3'd0;
            dz_next_q   <= 1'b0;
            q_bcd_q     <= 12'd0;
            r_bcd_q     <= 12'd0;
            dz_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            sq_q        <= sq_d;
            sr_q        <= sr_d;
            qacc_q      <= qacc_d;
            racc_q      <= racc_d;
            cnt_q       <= cnt_d;
            dz_next_q   <= dz_next_d;
            q_bcd_q     <= q_bcd_d;
            r_bcd_q     <= r_bcd_d;
            dz_err_q    <= dz_err_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.q_bcd     = q_bcd_q;
    assign bus.r_bcd     = r_bcd_q;
    assign bus.dz_err    = dz_err_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_div_bcd_formatter.sv
// tb/tb_div_bcd_formatter.sv - self-checking bench for div_bcd_formatter
module tb_div_bcd_formatter;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    div_bcd_formatter_if bus ();

    div_bcd_formatter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  q;
        logic [7:0]  rem;
        logic [7:0]  b;
        logic [11:0] eq;
        logic [11:0] er;
        logic        edz;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance until out_valid is seen; cyc is the number of edges taken, -1 on timeout
    task automatic wait_valid(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (bus.out_valid === 1'b1) begin
                cyc = k;
                break;
            end
        end
        if (cyc < 0) check("wait_valid_timeout", 32'd1, 32'd0);
    endtask

    // Drop div_done for a cycle, present operands, raise div_done and wait for the result
    task automatic run_conv(input logic [7:0] q, input logic [7:0] rem, input logic [7:0] b,
                            output int cyc);
        bus.div_done = 1'b0;
        tick();
        bus.div_q    = q;
        bus.div_rem  = rem;
        bus.div_b    = b;
        bus.div_done = 1'b1;
        wait_valid(cyc);
    endtask

    initial begin
        int lat;
        int bad;
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{q: 8'hFF, rem: 8'h00, b: 8'd1,  eq: 12'h255, er: 12'h000, edz: 1'b0};
        vecs[1] = '{q: 8'h07, rem: 8'h06, b: 8'd13, eq: 12'h007, er: 12'h006, edz: 1'b0};
        vecs[2] = '{q: 8'hFF, rem: 8'h2A, b: 8'd0,  eq: 12'h255, er: 12'h042, edz: 1'b1};
        vecs[3] = '{q: 8'h64, rem: 8'h63, b: 8'd2,  eq: 12'h100, er: 12'h099, edz: 1'b0};
        vecs[4] = '{q: 8'h00, rem: 8'h00, b: 8'd5,  eq: 12'h000, er: 12'h000, edz: 1'b0};
        vecs[5] = '{q: 8'h63, rem: 8'h0A, b: 8'd11, eq: 12'h099, er: 12'h010, edz: 1'b0};
        vecs[6] = '{q: 8'h0C, rem: 8'h59, b: 8'd90, eq: 12'h012, er: 12'h089, edz: 1'b0};

        // Reset with div_done already high
        reset         = 1'b1;
        bus.div_done  = 1'b1;
        bus.div_q     = 8'h12;
        bus.div_rem   = 8'h03;
        bus.div_b     = 8'd4;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_q_bcd", bus.q_bcd, 0);
        check("rst_r_bcd", bus.r_bcd, 0);
        check("rst_dz_err", bus.dz_err, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_overrun", bus.overrun, 0);
        reset = 1'b0;
        bad = 0;
        repeat (6) begin
            tick();
            if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) bad = 1;
        end
        check("held_done_no_start", bad, 0);

        // Table-driven conversions with out_ready held high
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            run_conv(vecs[i].q, vecs[i].rem, vecs[i].b, lat);
            check($sformatf("v%0d_latency", i), lat, 9);
            check($sformatf("v%0d_q_bcd", i), bus.q_bcd, vecs[i].eq);
            check($sformatf("v%0d_r_bcd", i), bus.r_bcd, vecs[i].er);
            check($sformatf("v%0d_dz_err", i), bus.dz_err, vecs[i].edz);
            check($sformatf("v%0d_busy_in_hold", i), bus.busy, 1);
            tick();
            check($sformatf("v%0d_valid_drop", i), bus.out_valid, 0);
            check($sformatf("v%0d_busy_drop", i), bus.busy, 0);
            check($sformatf("v%0d_q_kept", i), bus.q_bcd, vecs[i].eq);
        end

        // Stall: out_ready low for 5 cycles while the result is held
        bus.out_ready = 1'b0;
        run_conv(8'h07, 8'h06, 8'd13, lat);
        check("stall_latency", lat, 9);
        bad = 0;
        repeat (5) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.q_bcd !== 12'h007 || bus.r_bcd !== 12'h006) bad = 1;
        end
        check("stall_stable", bad, 0);
        bus.out_ready = 1'b1;
        tick();
        check("stall_handshake", bus.out_valid, 0);
        bad = 0;
        repeat (5) begin
            tick();
            if (bus.out_valid !== 1'b0) bad = 1;
        end
        check("stall_single_handshake", bad, 0);

        // Second div_done rise during CONV sets overrun, first result unaffected
        check("pre_overrun", bus.overrun, 0);
        bus.div_done = 1'b0;
        tick();
        bus.div_q    = 8'h2A;
        bus.div_rem  = 8'h05;
        bus.div_b    = 8'd7;
        bus.div_done = 1'b1;
        tick();
        tick();
        bus.div_done = 1'b0;
        bus.div_q    = 8'h01;
        bus.div_rem  = 8'h01;
        tick();
        bus.div_done = 1'b1;
        tick();
        check("overrun_set", bus.overrun, 1);
        check("overrun_busy", bus.busy, 1);
        wait_valid(lat);
        check("overrun_latency", lat, 5);
        check("overrun_q_bcd", bus.q_bcd, 12'h042);
        check("overrun_r_bcd", bus.r_bcd, 12'h005);
        tick();
        bad = 0;
        repeat (12) begin
            if (bus.out_valid !== 1'b0) bad = 1;
            tick();
        end
        check("overrun_no_second", bad, 0);
        check("overrun_sticky", bus.overrun, 1);

        // Back-to-back: next start coincides with the handshake
        bus.div_done = 1'b0;
        tick();
        bus.div_q    = 8'h0C;
        bus.div_rem  = 8'h59;
        bus.div_b    = 8'd90;
        bus.div_done = 1'b1;
        tick();
        tick();
        bus.div_done = 1'b0;
        wait_valid(lat);
        check("b2b_first_latency", lat, 7);
        check("b2b_first_q", bus.q_bcd, 12'h012);
        bus.div_q    = 8'h63;
        bus.div_rem  = 8'h0A;
        bus.div_b    = 8'd11;
        bus.div_done = 1'b1;
        tick();
        check("b2b_valid_drop", bus.out_valid, 0);
        check("b2b_busy_kept", bus.busy, 1);
        wait_valid(lat);
        check("b2b_second_latency", lat, 8);
        check("b2b_second_q", bus.q_bcd, 12'h099);
        check("b2b_second_r", bus.r_bcd, 12'h010);
        tick();
        check("b2b_done", bus.out_valid, 0);

        // Reset 4 cycles into CONV
        bus.div_done = 1'b0;
        tick();
        bus.div_q    = 8'hFF;
        bus.div_rem  = 8'h00;
        bus.div_b    = 8'd1;
        bus.div_done = 1'b1;
        tick();
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_q_bcd", bus.q_bcd, 0);
        check("midrst_r_bcd", bus.r_bcd, 0);
        check("midrst_dz_err", bus.dz_err, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_overrun", bus.overrun, 0);
        reset = 1'b0;
        run_conv(8'h64, 8'h63, 8'd2, lat);
        check("postrst_latency", lat, 9);
        check("postrst_q_bcd", bus.q_bcd, 12'h100);
        check("postrst_r_bcd", bus.r_bcd, 12'h099);
        tick();
        check("postrst_valid_drop", bus.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
